// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan driver: blanking codes, segment bit positions,
// the active-low hex glyph table and the per-frame input snapshot type.
package seg7_pkg;

   localparam logic [7:0] SEG_OFF   = 8'hFF;
   localparam logic [7:0] DIGIT_OFF = 8'hFF;

   localparam int unsigned SEG_A  = 0;
   localparam int unsigned SEG_B  = 1;
   localparam int unsigned SEG_C  = 2;
   localparam int unsigned SEG_D  = 3;
   localparam int unsigned SEG_E  = 4;
   localparam int unsigned SEG_F  = 5;
   localparam int unsigned SEG_G  = 6;
   localparam int unsigned SEG_DP = 7;

   // Entry n is the active-low {g,f,e,d,c,b,a} pattern for hex digit n.
   localparam logic [15:0][6:0] GLYPH_TABLE = {
      7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
      7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
   };

   typedef struct packed {
      logic [31:0] value;
      logic [7:0]  dp;
      logic [7:0]  en;
      logic [7:0]  blink;
      logic        lzb;
   } snap_t;

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Display-data and scan-output bundle between the timer control logic and the scan driver.
interface seg7_scan_driver_if;

   logic [31:0] VALUE;
   logic [7:0]  DP;
   logic [7:0]  DIGIT_EN;
   logic [7:0]  BLINK;
   logic        LZB;
   logic [7:0]  SEG;
   logic [7:0]  DIGIT;
   logic        FRAME;

   modport master (
      output VALUE, DP, DIGIT_EN, BLINK, LZB,
      input  SEG, DIGIT, FRAME
   );

   modport slave (
      input  VALUE, DP, DIGIT_EN, BLINK, LZB,
      output SEG, DIGIT, FRAME
   );

endinterface

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-low 7-segment glyph decoder.
module seg7_hex_decode
   import seg7_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] glyph
);

   always_comb begin
      glyph = GLYPH_TABLE[nibble];
   end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 8-digit common-anode scan driver with per-frame input snapshot,
// ghosting guard interval, blink and leading-zero blanking.
module seg7_scan_driver
   import seg7_pkg::*;
#(
   parameter int unsigned SCAN_DIV     = 12000,
   parameter int unsigned GUARD        = 16,
   parameter int unsigned BLINK_FRAMES = 31
) (
   input logic              CLK,
   input logic              RST,
   seg7_scan_driver_if.slave bus
);

   localparam int unsigned CW = $clog2(SCAN_DIV);
   localparam int unsigned FW = $clog2(BLINK_FRAMES + 1);
   localparam logic [CW-1:0] SLOT_LAST  = CW'(SCAN_DIV - 1);
   localparam logic [FW-1:0] BLINK_LAST = FW'(BLINK_FRAMES - 1);

   logic [CW-1:0] slot_cnt_q;
   logic [2:0]    digit_idx_q;
   logic [FW-1:0] blink_cnt_q;
   logic          phase_q;
   snap_t         snap_q;
   logic [7:0]    seg_q;
   logic [7:0]    anode_q;
   logic          frame_q;

   logic       slot_end;
   logic       frame_end;
   logic       in_guard;
   logic       visible;
   logic [7:0] lz_blank;
   logic [3:0] nibble;
   logic [6:0] glyph;
   logic [7:0] seg_d;
   logic [7:0] anode_d;

   assign slot_end  = (slot_cnt_q == SLOT_LAST);
   assign frame_end = slot_end && (digit_idx_q == 3'd7);

   generate
      if (GUARD == 0) begin : g_no_guard
         assign in_guard = 1'b0;
      end else begin : g_guard
         assign in_guard = (slot_cnt_q < CW'(GUARD));
      end
   endgenerate

   // Scan from the top digit down; a digit is blanked while nothing enabled above it is nonzero.
   always_comb begin
      logic upper_zero;
      upper_zero = 1'b1;
      lz_blank   = '0;
      for (int j = 7; j >= 1; j--) begin
         if (snap_q.en[j] && (snap_q.value[4*j +: 4] != 4'h0)) begin
            upper_zero = 1'b0;
         end
         lz_blank[j] = snap_q.lzb & upper_zero;
      end
   end

   assign nibble  = snap_q.value[{digit_idx_q, 2'b00} +: 4];
   assign visible = snap_q.en[digit_idx_q]
                    && !(phase_q && snap_q.blink[digit_idx_q])
                    && !lz_blank[digit_idx_q];

   seg7_hex_decode u_hex_decode (
      .nibble (nibble),
      .glyph  (glyph)
   );

   always_comb begin
      seg_d   = SEG_OFF;
      anode_d = DIGIT_OFF;
      if (!in_guard && visible) begin
         anode_d               = ~(8'b1 << digit_idx_q);
         seg_d[SEG_G:SEG_A]    = glyph;
         seg_d[SEG_DP]         = ~snap_q.dp[digit_idx_q];
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         slot_cnt_q  <= '0;
         digit_idx_q <= '0;
         blink_cnt_q <= '0;
         phase_q     <= 1'b0;
         snap_q      <= '0;
         seg_q       <= SEG_OFF;
         anode_q     <= DIGIT_OFF;
         frame_q     <= 1'b0;
      end else begin
         seg_q   <= seg_d;
         anode_q <= anode_d;
         frame_q <= frame_end;

         if (slot_end) begin
            slot_cnt_q  <= '0;
            digit_idx_q <= digit_idx_q + 3'd1;
         end else begin
            slot_cnt_q <= slot_cnt_q + CW'(1);
         end

         // Snapshot at the last cycle of digit 7 so a whole frame shows one consistent input set.
         if (frame_end) begin
            snap_q <= '{value: bus.VALUE, dp: bus.DP, en: bus.DIGIT_EN,
                        blink: bus.BLINK, lzb: bus.LZB};
            if (blink_cnt_q == BLINK_LAST) begin
               blink_cnt_q <= '0;
               phase_q     <= ~phase_q;
            end else begin
               blink_cnt_q <= blink_cnt_q + FW'(1);
            end
         end
      end
   end

   assign bus.SEG   = seg_q;
   assign bus.DIGIT = anode_q;
   assign bus.FRAME = frame_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver: per-frame expectations are queued from the inputs
// captured at each frame boundary and compared cycle by cycle against the scan outputs.
module tb_seg7_scan_driver;

   localparam int unsigned SCAN_DIV     = 4;
   localparam int unsigned GUARD        = 1;
   localparam int unsigned BLINK_FRAMES = 2;
   localparam int          FRAME_LEN    = 8 * SCAN_DIV;

   typedef struct {
      logic [7:0] seg;
      logic [7:0] digit;
      logic       frame;
      int         c;
   } exp_t;

   logic clk;
   logic rst;
   int   checks;
   int   passed;
   int   frames_seen;
   exp_t sb[$];

   // What the DUT shadow registers should hold for the frame being displayed.
   logic [31:0] sh_value;
   logic [7:0]  sh_dp;
   logic [7:0]  sh_en;
   logic [7:0]  sh_blink;
   logic        sh_lzb;

   seg7_scan_driver_if bus ();

   seg7_scan_driver #(
      .SCAN_DIV     (SCAN_DIV),
      .GUARD        (GUARD),
      .BLINK_FRAMES (BLINK_FRAMES)
   ) dut (
      .CLK (clk),
      .RST (rst),
      .bus (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk or posedge rst) begin
      if (rst) frames_seen <= 0;
      else if (bus.FRAME) frames_seen <= frames_seen + 1;
   end

   always @(negedge clk) begin
      if (!rst) begin
         checks++;
         if ($countones(~bus.DIGIT) > 1)
            $display("FAIL one_hot: DIGIT=%h, required at most one low bit", bus.DIGIT);
         else
            passed++;
      end
   end

   function automatic logic [6:0] ref_glyph(input logic [3:0] n);
      case (n)
         4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
         4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
         4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
         4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
      endcase
   endfunction

   function automatic void ref_out(input int k, input int c, input logic phase,
                                   output logic [7:0] seg, output logic [7:0] digit);
      int   top;
      logic lz;
      logic vis;
      seg   = 8'hFF;
      digit = 8'hFF;
      top   = -1;
      for (int j = 0; j < 8; j++)
         if (sh_en[j] && sh_value[4*j +: 4] != 4'h0) top = j;
      lz  = sh_lzb && (k >= 1) && (k > top);
      vis = sh_en[k] && !(phase && sh_blink[k]) && !lz;
      if (c >= int'(GUARD) && vis) begin
         digit[k] = 1'b0;
         seg      = {~sh_dp[k], ref_glyph(sh_value[4*k +: 4])};
      end
   endfunction

   task automatic wait_frame();
      int n;
      n = 0;
      while (bus.FRAME !== 1'b1 && n < 4 * FRAME_LEN) begin
         @(negedge clk);
         n++;
      end
      if (bus.FRAME !== 1'b1) begin
         checks++;
         $display("FAIL frame_timeout: FRAME=%b, required 1 within %0d cycles", bus.FRAME, n);
      end
   endtask

   // Queue one frame of expectations, then compare as the DUT scans it out.
   task automatic step_frame(input bit sync, input string tag, input int change_at,
                             input logic [31:0] new_value, input int stop_at);
      int         n;
      logic       phase;
      logic [7:0] s;
      logic [7:0] d;
      exp_t       e;
      if (sync) wait_frame();
      n     = sync ? frames_seen + 1 : 0;
      phase = ((n / int'(BLINK_FRAMES)) % 2) == 1;
      for (int i = 1; i <= FRAME_LEN; i++) begin
         ref_out((i - 1) / SCAN_DIV, (i - 1) % SCAN_DIV, phase, s, d);
         e.seg   = s;
         e.digit = d;
         e.frame = (i == FRAME_LEN);
         e.c     = (i - 1) % SCAN_DIV;
         sb.push_back(e);
      end
      for (int i = 1; i <= stop_at; i++) begin
         if (i == change_at) bus.VALUE = new_value;
         @(negedge clk);
         e = sb.pop_front();
         checks++;
         if ({bus.DIGIT, bus.SEG, bus.FRAME} !== {e.digit, e.seg, e.frame})
            $display("FAIL %s[%0d]: DIGIT/SEG/FRAME=%h/%h/%b, required %h/%h/%b", tag, i,
                     bus.DIGIT, bus.SEG, bus.FRAME, e.digit, e.seg, e.frame);
         else
            passed++;
         if (e.c < int'(GUARD)) begin
            checks++;
            if (bus.DIGIT !== 8'hFF)
               $display("FAIL %s_guard[%0d]: DIGIT=%h, required ff", tag, i, bus.DIGIT);
            else
               passed++;
         end
      end
      sb.delete();
      sh_value = bus.VALUE;
      sh_dp    = bus.DP;
      sh_en    = bus.DIGIT_EN;
      sh_blink = bus.BLINK;
      sh_lzb   = bus.LZB;
   endtask

   task automatic check_reset_outputs(input string tag);
      checks++;
      if ({bus.DIGIT, bus.SEG, bus.FRAME} !== {8'hFF, 8'hFF, 1'b0})
         $display("FAIL %s: DIGIT/SEG/FRAME=%h/%h/%b, required ff/ff/0", tag,
                  bus.DIGIT, bus.SEG, bus.FRAME);
      else
         passed++;
   endtask

   task automatic clear_shadow();
      sh_value = '0;
      sh_dp    = '0;
      sh_en    = '0;
      sh_blink = '0;
      sh_lzb   = 1'b0;
   endtask

   task automatic test_reset();
      rst          = 1'b1;
      bus.VALUE    = '0;
      bus.DP       = '0;
      bus.DIGIT_EN = '0;
      bus.BLINK    = '0;
      bus.LZB      = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset_state");
      bus.VALUE    = 32'h0000_0159;
      bus.DIGIT_EN = 8'h07;
      clear_shadow();
      rst = 1'b0;
      step_frame(1'b0, "reset_dark", 0, '0, FRAME_LEN);
      step_frame(1'b1, "first_frame", 0, '0, FRAME_LEN);
   endtask

   task automatic test_lzb();
      bus.LZB      = 1'b1;
      bus.DIGIT_EN = 8'hFF;
      bus.VALUE    = 32'h0000_0007;
      step_frame(1'b1, "lzb_pre", 0, '0, FRAME_LEN);
      step_frame(1'b1, "lzb_seven", 0, '0, FRAME_LEN);
      bus.VALUE = 32'h0000_0000;
      step_frame(1'b1, "lzb_pre0", 0, '0, FRAME_LEN);
      step_frame(1'b1, "lzb_zero", 0, '0, FRAME_LEN);
      bus.VALUE = 32'h00A0_0300;
      step_frame(1'b1, "lzb_pre_mix", 0, '0, FRAME_LEN);
      step_frame(1'b1, "lzb_mix", 0, '0, FRAME_LEN);
   endtask

   task automatic test_blink();
      bus.LZB      = 1'b0;
      bus.DIGIT_EN = 8'h01;
      bus.DP       = 8'h01;
      bus.BLINK    = 8'h01;
      bus.VALUE    = 32'h0000_0008;
      for (int f = 0; f < 6; f++) step_frame(1'b1, "blink", 0, '0, FRAME_LEN);
   endtask

   task automatic test_mid_frame();
      bus.BLINK    = 8'h00;
      bus.DP       = 8'h00;
      bus.DIGIT_EN = 8'h07;
      bus.VALUE    = 32'h0000_0123;
      step_frame(1'b1, "mid_pre", 0, '0, FRAME_LEN);
      step_frame(1'b1, "mid_base", 0, '0, FRAME_LEN);
      step_frame(1'b1, "mid_change", 13, 32'h0000_0456, FRAME_LEN);
      step_frame(1'b1, "mid_after", 0, '0, FRAME_LEN);
   endtask

   task automatic test_reset_mid();
      bus.DIGIT_EN = 8'hFF;
      bus.DP       = 8'h20;
      bus.VALUE    = 32'h8765_4321;
      step_frame(1'b1, "rm_pre", 0, '0, FRAME_LEN);
      step_frame(1'b1, "rm_slot5", 0, '0, 23);
      rst = 1'b1;
      #1;
      check_reset_outputs("reset_async");
      repeat (2) @(negedge clk);
      check_reset_outputs("reset_held");
      clear_shadow();
      rst = 1'b0;
      step_frame(1'b0, "rm_dark", 0, '0, FRAME_LEN);
      step_frame(1'b1, "rm_first", 0, '0, FRAME_LEN);
   endtask

   initial begin
      checks = 0;
      passed = 0;
      rst    = 1'b1;
      clear_shadow();
      test_reset();
      test_lzb();
      test_blink();
      test_mid_frame();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
